freq_gate_counter: RTL and testbench

// - Gated edge counter: front end of the frequency counter. Counts rising edges of an

---
 rtl/freq_gate_counter_pkg.sv | 15 +
 rtl/freq_gate_counter_sync_edge_detect.sv | 29 ++
 rtl/freq_gate_counter.sv | 109 ++++++++++
 tb/tb_freq_gate_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gate_counter_pkg.sv
// rtl/freq_gate_counter_pkg.sv - shared state encodings and defaults for the frequency counter
package freq_gate_counter_pkg;

  // Encodings are shared with the display/BCD path, so keep them fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Four BCD digits downstream, so the published count tops out at 9999.
  localparam int DEF_MAX_COUNT = 9999;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/freq_gate_counter_sync_edge_detect.sv
// rtl/freq_gate_counter_sync_edge_detect.sv - async input synchronizer with rising-edge detect
module sync_edge_detect
  import freq_gate_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the synchronizer; prev_q trails the last stage by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_gate_counter.sv
// rtl/freq_gate_counter.sv - gated edge counter publishing a saturating count per gate window
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = DEF_MAX_COUNT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             gate_active
);

  localparam int GW = $clog2(GATE_CYCLES);
  // A fresh window spends GATE_CYCLES cycles in GATE; a back-to-back window also
  // counts the LATCH cycle, so its GATE phase is one cycle shorter.
  localparam logic [GW-1:0]    GATE_LOAD   = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_RELOAD = GW'(GATE_CYCLES - 2);
  localparam logic [CNT_W-1:0] MAX_C       = CNT_W'(MAX_COUNT);

  state_t           state;
  state_t           state_nx;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_flag;
  logic             rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_async(sig_in),
    .rise   (rise)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: dropping enable mid-window aborts without publishing.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = GATE;
      GATE: begin
        if (!enable)             state_nx = IDLE;
        else if (gate_cnt == '0) state_nx = LATCH;
      end
      LATCH:   state_nx = enable ? GATE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign gate_active = (state == GATE) || (state == LATCH);

  // Gate timer and saturating edge counter; an edge seen during LATCH opens the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        GATE: begin
          gate_cnt <= gate_cnt - GW'(1);
          if (rise) begin
            if (edge_cnt == MAX_C) ovf_flag <= 1'b1;
            else                   edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
        LATCH: begin
          gate_cnt <= GATE_RELOAD;
          edge_cnt <= rise ? CNT_W'(1) : '0;
          ovf_flag <= 1'b0;
        end
        default: begin
          gate_cnt <= GATE_LOAD;
          edge_cnt <= '0;
          ovf_flag <= 1'b0;
        end
      endcase
    end
  end

  // Publish the closed window's result; count_out and overflow hold until the next LATCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out   <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= (state == LATCH);
      if (state == LATCH) begin
        count_out <= edge_cnt;
        overflow  <= ovf_flag;
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// tb/tb_freq_gate_counter.sv - randomized self-checking bench for freq_gate_counter
module tb_freq_gate_counter;

  localparam int G     = 100;
  localparam int MAX_A = 9999;
  localparam int MAX_B = 20;
  localparam int HLEN  = 16384;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        sig_in = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] count_a, count_b;
  logic        valid_a, valid_b, ovf_a, ovf_b, gact_a, gact_b;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int val_cnt = 0;
  bit mon_on  = 1'b0;
  bit hist [HLEN];

  bit gen_on = 1'b0;
  bit lvl    = 1'b0;
  int hi_ns  = 20;
  int lo_ns  = 20;

  freq_gate_counter #(.GATE_CYCLES(G), .MAX_COUNT(MAX_A)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
    .count_out(count_a), .count_valid(valid_a), .overflow(ovf_a), .gate_active(gact_a)
  );

  freq_gate_counter #(.GATE_CYCLES(G), .MAX_COUNT(MAX_B)) dut_sat (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
    .count_out(count_b), .count_valid(valid_b), .overflow(ovf_b), .gate_active(gact_b)
  );

  always #5 clk = ~clk;

  // Signal source: all transitions land 2 units after a multiple of 10, never on a clock edge.
  initial begin
    #2;
    forever begin
      if (gen_on) begin
        sig_in = 1'b1; #(hi_ns);
        sig_in = 1'b0; #(lo_ns);
      end else begin
        sig_in = lvl; #10;
      end
    end
  end

  // Record the input level as the synchronizer's first stage captures it.
  always @(posedge clk) begin
    if (cyc < HLEN) hist[cyc] = rst ? 1'b0 : sig_in;
    cyc++;
  end

  task check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A window published after edge v counts rises captured at edges v-G-2 .. v-3.
  function automatic int model_edges(input int v);
    int n = 0;
    for (int m = v - G - 2; m <= v - 3; m++)
      if (m >= 1 && m < HLEN && hist[m] && !hist[m-1]) n++;
    return n;
  endfunction

  // Every published result of both instances is compared against the level-history model.
  always @(negedge clk) begin : mon
    int n;
    if (mon_on && valid_a) begin
      val_cnt++;
      n = model_edges(cyc - 1);
      check("win_count", count_a, (n > MAX_A) ? MAX_A : n);
      check("win_ovf", ovf_a, (n > MAX_A) ? 1 : 0);
      check("sat_win_count", count_b, (n > MAX_B) ? MAX_B : n);
      check("sat_win_ovf", ovf_b, (n > MAX_B) ? 1 : 0);
      check("sat_valid_aligned", valid_b, 1);
    end
  end

  task wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid_a && k < 400);
    if (!valid_a) check("valid_timeout", valid_a, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k;
    int base;
    bit gseen;

    // Reset with the input toggling and enable high: reset must win.
    gen_on = 1'b1;
    enable = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_gate_active", gact_a, 0);
    check("rst_sat_count", count_b, 0);
    rst    = 1'b0;
    enable = 1'b0;
    mon_on = 1'b1;

    // Idle: no windows while enable is low.
    base  = val_cnt;
    gseen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (gact_a) gseen = 1'b1;
    end
    check("idle_no_valid", val_cnt - base, 0);
    check("idle_gate_active", gseen, 0);

    // Steady 40-unit period: 25 rises per window, saturating instance clamps at 20.
    enable = 1'b1;
    wait_valid(k);
    check("first_latency", k, G + 2);
    for (int i = 0; i < 3; i++) begin
      wait_valid(k);
      check("steady_spacing", k, G);
      check("steady_count", count_a, 25);
      check("steady_ovf", ovf_a, 0);
      check("sat_count_max", count_b, MAX_B);
      check("sat_ovf_set", ovf_b, 1);
      check("steady_gate_active", gact_a, 1);
    end

    // Slower 100-unit period: 10 rises; the saturating instance recovers.
    hi_ns = 50;
    lo_ns = 50;
    wait_valid(k);
    wait_valid(k);
    check("slow_spacing", k, G);
    check("slow_count", count_a, 10);
    check("slow_sat_count", count_b, 10);
    check("slow_sat_ovf", ovf_b, 0);

    // Abort at cycle 50 of a window: nothing published, previous result held.
    repeat (49) @(negedge clk);
    enable = 1'b0;
    base   = val_cnt;
    repeat (150) @(negedge clk);
    check("abort_no_valid", val_cnt - base, 0);
    check("abort_hold_count", count_a, 10);
    check("abort_idle", gact_a, 0);
    enable = 1'b1;
    wait_valid(k);
    check("reenable_latency", k, G + 2);

    // Random periods, including rates above clk/4; counts checked by the model.
    for (int w = 0; w < 8; w++) begin
      hi_ns = 10 * $urandom_range(1, 6);
      lo_ns = 10 * $urandom_range(1, 6);
      wait_valid(k);
      check("rand_spacing", k, G);
    end

    // Single rise whose synced edge lands in the last GATE cycle.
    enable = 1'b0;
    gen_on = 1'b0;
    lvl    = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    repeat (G - 2) @(negedge clk);
    lvl = 1'b1;
    wait_valid(k);
    check("last_gate_latency", k, 4);
    check("last_gate_count", count_a, 1);
    wait_valid(k);
    check("last_gate_next", count_a, 0);

    // Single rise whose synced edge lands in the LATCH cycle.
    enable = 1'b0;
    lvl    = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    repeat (G - 1) @(negedge clk);
    lvl = 1'b1;
    wait_valid(k);
    check("latch_edge_first", count_a, 0);
    wait_valid(k);
    check("latch_edge_next", count_a, 1);

    // Reset in the middle of a window.
    gen_on = 1'b1;
    hi_ns  = 20;
    lo_ns  = 20;
    wait_valid(k);
    wait_valid(k);
    repeat (59) @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("midrst_count", count_a, 0);
    check("midrst_ovf", ovf_a, 0);
    check("midrst_valid", valid_a, 0);
    check("midrst_gate_active", gact_a, 0);
    check("midrst_sat_ovf", ovf_b, 0);
    rst  = 1'b0;
    base = val_cnt;
    repeat (150) @(negedge clk);
    check("midrst_no_valid", val_cnt - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
